// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 core and its program loader.
package mips32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_CKSUM
  } ldr_state_t;

  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
  localparam int unsigned IMEM_DEPTH   = 1024;

endpackage

// File: rtl/loader_byte_asm.sv
// Shifts data bytes into 32-bit words (MSB first) and keeps the running XOR checksum.
// word_o/word_done_o are combinational so the loader can register the write on the 4th byte.
module loader_byte_asm (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o,
  output logic [7:0]  xor_o
);

  logic [23:0] part_q, part_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  xor_q, xor_d;

  always_comb begin
    part_d = part_q;
    cnt_d  = cnt_q;
    xor_d  = xor_q;
    if (clr_i) begin
      part_d = '0;
      cnt_d  = '0;
      xor_d  = '0;
    end else if (shift_i) begin
      part_d = {part_q[15:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
      xor_d  = xor_q ^ byte_i;
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      part_q <= '0;
      cnt_q  <= '0;
      xor_q  <= '0;
    end else begin
      part_q <= part_d;
      cnt_q  <= cnt_d;
      xor_q  <= xor_d;
    end
  end

  // The byte counter wraps to 0 after the 4th byte, so each word starts aligned.
  assign word_o      = {part_q, byte_i};
  assign word_done_o = shift_i && (cnt_q == 2'd3);
  assign xor_o       = xor_q;

endmodule

// File: rtl/mips32_prog_loader.sv
// Byte-stream frame loader: writes words into instruction/data memory, then releases the CPU.
// Stalls the input for exactly the cycle in which a word write is presented.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int         ADDR_W = $clog2(IMEM_DEPTH),
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_halt,
  output logic              cpu_start,
  output logic              load_err
);

  ldr_state_t        state_q;
  logic [7:0]        addr_hi_q;
  logic [7:0]        cnt_hi_q;
  logic [15:0]       words_left_q;
  logic [ADDR_W-1:0] addr_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_halt_q;
  logic              cpu_start_q;
  logic              load_err_q;

  logic        accept;
  logic        asm_clr;
  logic        asm_shift;
  logic [31:0] asm_word;
  logic        asm_done;
  logic [7:0]  asm_xor;

  assign accept    = in_valid && in_ready_q;
  assign asm_clr   = accept && (state_q == ST_IDLE) && (in_data == SYNC);
  assign asm_shift = accept && (state_q == ST_DATA);

  loader_byte_asm u_asm (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .clr_i       (asm_clr),
    .shift_i     (asm_shift),
    .byte_i      (in_data),
    .word_o      (asm_word),
    .word_done_o (asm_done),
    .xor_o       (asm_xor)
  );

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_hi_q    <= '0;
      cnt_hi_q     <= '0;
      words_left_q <= '0;
      addr_q       <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_halt_q   <= 1'b0;
      cpu_start_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      cpu_start_q <= 1'b0;
      in_ready_q  <= 1'b1;
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            if (in_data == SYNC) begin
              state_q    <= ST_ADDR_HI;
              cpu_halt_q <= 1'b1;
            end
          end
          ST_ADDR_HI: begin
            addr_hi_q <= in_data;
            state_q   <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            addr_q  <= ADDR_W'({addr_hi_q, in_data});
            state_q <= ST_CNT_HI;
          end
          ST_CNT_HI: begin
            cnt_hi_q <= in_data;
            state_q  <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            words_left_q <= {cnt_hi_q, in_data};
            state_q      <= ({cnt_hi_q, in_data} == 16'd0) ? ST_CKSUM : ST_DATA;
          end
          ST_DATA: begin
            // Drop ready while the write is visible so the next byte cannot overlap it.
            if (asm_done) begin
              mem_we_q     <= 1'b1;
              in_ready_q   <= 1'b0;
              mem_addr_q   <= addr_q;
              mem_wdata_q  <= asm_word;
              addr_q       <= addr_q + ADDR_W'(1);
              words_left_q <= words_left_q - 16'd1;
              if (words_left_q == 16'd1) state_q <= ST_CKSUM;
            end
          end
          ST_CKSUM: begin
            if (in_data == asm_xor) begin
              cpu_start_q <= 1'b1;
              cpu_halt_q  <= 1'b0;
              load_err_q  <= 1'b0;
            end else begin
              load_err_q  <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_halt  = cpu_halt_q;
  assign cpu_start = cpu_start_q;
  assign load_err  = load_err_q;

endmodule

// File: doc/mips32_prog_loader.md
MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width of the instruction/data memory write port.
REQ-002 Parameter SYNC, default 8'hA5: frame start byte.
REQ-003 clk1  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_data  input  8  byte stream payload.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  loader accepts in_data; a byte transfers when in_valid and in_ready are both high.
REQ-008 mem_we  output  1  one-cycle word write strobe.
REQ-009 mem_addr  output  ADDR_W  word address of the write.
REQ-010 mem_wdata  output  32  word written.
REQ-011 cpu_halt  output  1  holds the processor halted while a frame is in progress.
REQ-012 cpu_start  output  1  one-cycle pulse: clear HALTED, PC=0, TAKEN_BRANCH=0 in the processor.
REQ-013 load_err  output  1  sticky frame-error flag.

Function
REQ-014 Frame format: SYNC, addr_hi, addr_lo, cnt_hi, cnt_lo, then cnt words of 4 bytes each (MSB first), then one checksum byte equal to the XOR of all data bytes.
REQ-015 States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CKSUM; each accepted byte advances exactly one step.
REQ-016 IDLE: a non-SYNC byte is discarded; SYNC moves to ADDR_HI, sets cpu_halt=1 and clears the checksum accumulator.
REQ-017 Start address = {addr_hi,addr_lo}[ADDR_W-1:0]; upper bits are ignored.
REQ-018 cnt = {cnt_hi,cnt_lo}, 16 bits; cnt=0 goes from CNT_LO directly to CKSUM.
REQ-019 DATA: bytes shift into a 32-bit assembly register; on the 4th byte of a word, mem_we=1 for exactly the next cycle with mem_wdata = assembled word and mem_addr = current address.
REQ-020 Address increments by 1 after each word write and wraps from 2^ADDR_W-1 to 0.
REQ-021 After the last word, the FSM moves to CKSUM.
REQ-022 CKSUM match: cpu_start pulses for one cycle, cpu_halt drops to 0 in the same cycle, load_err is cleared, and the FSM returns to IDLE.
REQ-023 CKSUM mismatch: load_err=1, no cpu_start, cpu_halt stays 1, and the FSM returns to IDLE.
REQ-024 in_ready=1 in all states except the cycle in which mem_we is asserted; no byte is lost.
REQ-025 A SYNC byte received in DATA is treated as data, not as a restart.
REQ-026 Outputs are registered; latency from the 4th data byte to mem_we is 1 cycle, and from the checksum byte to cpu_start is 1 cycle.
REQ-027 A new frame may start immediately after CKSUM, including the cycle after cpu_start.

Reset
REQ-028 On rst_n=0 at a rising edge, the FSM goes to IDLE and all registers clear.
REQ-029 Outputs during and after reset: in_ready=0 while rst_n=0, and 1 from the first edge with rst_n=1; mem_we=0; mem_addr=0; mem_wdata=0; cpu_halt=0; cpu_start=0; load_err=0.
REQ-030 Reset mid-frame abandons the frame: no further writes, no cpu_start.

Structure
REQ-031 A shared package mips32_pkg holds the FSM state enum, the SYNC default, and the memory depth constant, shared with the processor top.
REQ-032 One sub-module, loader_byte_asm, holds the 4-byte-to-word assembler with its byte counter and XOR accumulator; the FSM stays in mips32_prog_loader.

Verification
REQ-033 Frame A5 00 00 00 02 28 0A 00 C8 28 02 00 01 plus checksum -> writes 280a00c8@0 and 28020001@1, then cpu_start pulse, cpu_halt=0, load_err=0.
REQ-034 The same frame with the checksum XORed by 0x01 -> both writes occur, load_err=1, no cpu_start, cpu_halt=1.
REQ-035 Start address 0x03FF with cnt=2 -> writes at 1023 then 0.
REQ-036 cnt=0 with checksum 00 -> no mem_we, cpu_start pulses.
REQ-037 Garbage bytes 11 22 before SYNC, and in_valid toggled every other cycle -> same result as REQ-033.
REQ-038 rst_n low after the 6th data byte -> only word @0 is written, all outputs match their reset values, and a following full frame loads normally.
